// File: rtl/sc_inst_encoder.sv
// Packs decoded instruction fields into 32-bit MIPS words and streams them with
// sequential imem addresses. Optional build macro: ENC_ILLEGAL_TRAP_EN (trap illegal mnemonics).
module sc_inst_encoder #(
  parameter int AW = 6
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    mnem,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    sa,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_inst,
  output logic [AW-1:0] out_addr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   inst_q, inst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   enc_word;
  logic          accept, xfer, emit;

  // Illegal mnemonics fall through to the all-zero word, which is a MIPS NOP.
  always_comb begin
    // NOTE: default first so every path assigns enc_word and no latch is inferred.
    enc_word = 32'h0;
    case (mnem)
      5'd0:  enc_word = {6'b000000, rs, rt, rd, sa, 6'b100000};
      5'd1:  enc_word = {6'b000000, rs, rt, rd, sa, 6'b100010};
      5'd2:  enc_word = {6'b000000, rs, rt, rd, sa, 6'b100100};
      5'd3:  enc_word = {6'b000000, rs, rt, rd, sa, 6'b100101};
      5'd4:  enc_word = {6'b000000, rs, rt, rd, sa, 6'b100110};
      5'd5:  enc_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000000};
      5'd6:  enc_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000010};
      5'd7:  enc_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000011};
      5'd8:  enc_word = {6'b000000, rs, 15'd0, 6'b001000};
      5'd9:  enc_word = {6'b001000, rs, rt, imm};
      5'd10: enc_word = {6'b001100, rs, rt, imm};
      5'd11: enc_word = {6'b001101, rs, rt, imm};
      5'd12: enc_word = {6'b001110, rs, rt, imm};
      5'd13: enc_word = {6'b100011, rs, rt, imm};
      5'd14: enc_word = {6'b101011, rs, rt, imm};
      5'd15: enc_word = {6'b000100, rs, rt, imm};
      5'd16: enc_word = {6'b000101, rs, rt, imm};
      5'd17: enc_word = {6'b001111, 5'd0, rt, imm};
      5'd18: enc_word = {6'b000010, target};
      5'd19: enc_word = {6'b000011, target};
      default: enc_word = 32'h0;
    endcase
  end

  assign full      = (count_q == DEPTH);
  assign out_valid = (state_q == HOLD);
  assign in_ready  = ~full & ~clear & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
  logic illegal, err_q, err_d;

  assign illegal = (mnem > 5'd19);
  assign emit    = accept & ~illegal;

  always_comb begin
    err_d = err_q;
    if (clear)                  err_d = 1'b0;
    else if (accept & illegal)  err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err = err_q;
`else
  assign emit = accept;
  assign err  = 1'b0;
`endif

  // A new word takes priority over draining, so transfer+accept stays in HOLD.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (clear) begin
      state_d = EMPTY;
      inst_d  = 32'h0;
      addr_d  = '0;
      ptr_d   = '0;
      count_d = '0;
    end else if (emit) begin
      state_d = HOLD;
      inst_d  = enc_word;
      addr_d  = ptr_q;
      ptr_d   = ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(1);
    end else if (xfer) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      inst_q  <= 32'h0;
      addr_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign out_inst = inst_q;
  assign out_addr = addr_q;
  assign count    = count_q;

endmodule

// File: tb/tb_sc_inst_encoder.sv
// Self-checking bench for sc_inst_encoder: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model (honours ENC_ILLEGAL_TRAP_EN).
module tb_sc_inst_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef ENC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    mnem = '0, rs = '0, rt = '0, rd = '0, sa = '0;
  logic [15:0]   imm = '0;
  logic [25:0]   target = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  sc_inst_encoder #(.AW(AW)) dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .count(count), .full(full), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else             n_pass++;
  endtask

  // Encoding from the instruction tables: field positions and opcode/func values.
  function automatic logic [31:0] model_enc(input logic [31:0] m, r_s, r_t, r_d, s_a, im, tg);
    logic [31:0] rfunc [8];
    logic [31:0] iop [9];
    rfunc = '{32'd32, 32'd34, 32'd36, 32'd37, 32'd38, 32'd0, 32'd2, 32'd3};
    iop   = '{32'd8, 32'd12, 32'd13, 32'd14, 32'd35, 32'd43, 32'd4, 32'd5, 32'd15};
    if (m <= 4)  return (r_s << 21) | (r_t << 16) | (r_d << 11) | (s_a << 6) | rfunc[m];
    if (m <= 7)  return (r_t << 16) | (r_d << 11) | (s_a << 6) | rfunc[m];
    if (m == 8)  return (r_s << 21) | 32'd8;
    if (m <= 17) return (iop[m-9] << 26) | ((m == 17) ? 32'd0 : (r_s << 21)) | (r_t << 16) | im;
    if (m <= 19) return ((m - 16) << 26) | tg;
    return 32'h0;
  endfunction

  bit          m_valid = 0;
  logic [31:0] m_inst  = 0;
  int          m_addr  = 0;
  int          m_ptr   = 0;
  int          m_count = 0;
  bit          m_err   = 0;

  always @(posedge clock or negedge resetn) begin
    bit rdy, acc, xfer, word;
    if (!resetn) begin
      m_valid = 0; m_inst = 0; m_addr = 0; m_ptr = 0; m_count = 0; m_err = 0;
    end else if (clear) begin
      m_valid = 0; m_ptr = 0; m_count = 0; m_err = 0;
    end else begin
      rdy  = (m_count != DEPTH) && (!m_valid || out_ready);
      acc  = in_valid && rdy;
      xfer = m_valid && out_ready;
      word = acc && !(TRAP && (mnem > 5'd19));
      if (acc && !word) m_err = 1;
      if (word) begin
        m_inst  = model_enc(32'(mnem), 32'(rs), 32'(rt), 32'(rd), 32'(sa), 32'(imm), 32'(target));
        m_addr  = m_ptr;
        m_valid = 1;
        m_ptr   = (m_ptr + 1) % DEPTH;
        m_count = m_count + 1;
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      check("in_ready", 32'(in_ready), 32'((m_count != DEPTH) && !clear && (!m_valid || out_ready)));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("out_inst", out_inst, m_inst);
        check("out_addr", 32'(out_addr), 32'(m_addr));
      end
      check("count", 32'(count), 32'(m_count));
      check("full", 32'(full), 32'(m_count == DEPTH));
      check("err", 32'(err), 32'(m_err));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts.
  task automatic send(input int m, input int r_s, input int r_t, input int r_d,
                      input int s_a, input int im, input int tg);
    int waits = 0;
    mnem = 5'(m); rs = 5'(r_s); rt = 5'(r_t); rd = 5'(r_d); sa = 5'(s_a);
    imm = 16'(im); target = 26'(tg); in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clock);
    end
    check("send_wait", 32'(waits), 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    out_ready = 1'b1;
    send(0, 1, 2, 3, 0, 0, 0);
    check("add_inst", out_inst, 32'h00221820);
    check("add_addr", 32'(out_addr), 32'd0);
    check("add_count", 32'(count), 32'd1);

    do_clear();
    send(9, 0, 1, 0, 0, 16'h0005, 0);
    check("addi_inst", out_inst, 32'h20010005);
    check("addi_addr", 32'(out_addr), 32'd0);
    send(13, 1, 2, 0, 0, 16'h0004, 0);
    check("lw_inst", out_inst, 32'h8C220004);
    check("lw_addr", 32'(out_addr), 32'd1);
    check("lw_count", 32'(count), 32'd2);

    do_clear();
    send(5, 7, 2, 3, 4, 0, 0);
    check("sll_inst", out_inst, 32'h00021900);
    send(18, 0, 0, 0, 0, 0, 26'h0000010);
    check("j_inst", out_inst, 32'h08000010);

    do_clear();
    out_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 0);
    mnem = 5'd3; rs = 5'd4; rt = 5'd5; rd = 5'd6; sa = 5'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_inst", out_inst, 32'h00221820);
      check("stall_count", 32'(count), 32'd1);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("or_inst", out_inst, 32'h00853025);
    check("or_addr", 32'(out_addr), 32'd1);

    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      send(0, 1, 2, i, 0, 0, 0);
      check("fill_addr", 32'(out_addr), 32'(i));
    end
    in_valid = 1'b1;
    @(negedge clock);
    check("full_flag", 32'(full), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'(DEPTH));
    repeat (3) @(posedge clock);
    #1 in_valid = 1'b0;
    check("full_hold_count", 32'(count), 32'(DEPTH));
    do_clear();
    check("clear_count", 32'(count), 32'd0);
    send(1, 3, 4, 5, 0, 0, 0);
    check("after_clear_addr", 32'(out_addr), 32'd0);

    do_clear();
    send(25, 9, 9, 9, 9, 16'hFFFF, 26'h3FFFFFF);
    if (TRAP) begin
      check("illegal_err", 32'(err), 32'd1);
      check("illegal_valid", 32'(out_valid), 32'd0);
      check("illegal_count", 32'(count), 32'd0);
    end else begin
      check("illegal_inst", out_inst, 32'h0);
      check("illegal_valid", 32'(out_valid), 32'd1);
      check("illegal_count", 32'(count), 32'd1);
    end
    do_clear();

    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        resetn = 1'b0;
        #2;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
      end
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      clear     = ($urandom_range(0, 39) == 0);
      mnem = 5'($urandom_range(0, 31));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom);
      imm = 16'($urandom); target = 26'($urandom);
      @(posedge clock); #1;
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
